// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int unsigned MCAUSE_INT_BIT = 31;
  localparam int unsigned IRQ_CODE_BASE  = 16;
  localparam int unsigned IRQ_ID_W       = 4;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt set.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 16
) (
  input  logic [N_IRQ-1:0]    req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching, maskable, fixed-priority interrupt source for the M-mode trap path.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [31:0]      mie_i,
  input  logic             int_ack_i,
  input  logic             mret_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] pending_o
);

  irq_state_e          state_q, state_d;
  logic [N_IRQ-1:0]    irq_q;
  logic [N_IRQ-1:0]    pending_q, pending_d;
  logic [N_IRQ-1:0]    rise, eligible, clr;
  logic [IRQ_ID_W-1:0] win_q, win_d, enc_id;
  logic                enc_valid;
  logic                int_d;
  logic [31:0]         mcause_d;
  logic                unused_mie;

  assign unused_mie = ^mie_i[31:N_IRQ];

  assign rise     = irq_i & ~irq_q;
  assign eligible = pending_q & mie_i[N_IRQ-1:0];

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // Next state and next registered outputs; the winner is frozen once committed.
  always_comb begin
    state_d  = state_q;
    int_d    = int_o;
    mcause_d = mcause_o;
    win_d    = win_q;
    clr      = '0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          win_d    = enc_id;
          mcause_d = (32'd1 << MCAUSE_INT_BIT) | (32'(IRQ_CODE_BASE) + 32'(enc_id));
          int_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (int_ack_i) begin
          clr     = N_IRQ'(1) << win_q;
          int_d   = 1'b0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (mret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge in the ack cycle survives the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      win_q     <= '0;
      int_o     <= 1'b0;
      mcause_o  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_i;
      pending_q <= pending_d;
      win_q     <= win_d;
      int_o     <= int_d;
      mcause_o  <= mcause_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenario bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

  localparam int unsigned N_IRQ = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N_IRQ-1:0] irq_i;
  logic [31:0]      mie_i;
  logic             int_ack_i;
  logic             mret_i;
  logic             int_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] pending_o;

  int vectors = 0;
  int miscompares = 0;

  irq_controller #(.N_IRQ(N_IRQ)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .irq_i     (irq_i),
    .mie_i     (mie_i),
    .int_ack_i (int_ack_i),
    .mret_i    (mret_i),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; irq_i = '0; mie_i = '0; int_ack_i = 1'b0; mret_i = 1'b0;
    #23;
    vectors++;
    if (int_o !== 1'b0) begin miscompares++; $display("FAIL reset_int: got %b want 0", int_o); end
    vectors++;
    if (mcause_o !== 32'h0) begin miscompares++; $display("FAIL reset_mcause: got %h want 0", mcause_o); end
    vectors++;
    if (pending_o !== 16'h0) begin miscompares++; $display("FAIL reset_pending: got %h want 0", pending_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    mie_i = 32'h8;
    irq_i = 16'h0008;
    tick();
    irq_i = '0;
    vectors++;
    if (pending_o !== 16'h0008 || int_o !== 1'b0) begin
      miscompares++; $display("FAIL basic_latch: pend %h int %b want 0008/0", pending_o, int_o);
    end
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0013) begin
      miscompares++; $display("FAIL basic_req: int %b mcause %h want 1/80000013", int_o, mcause_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0) begin
      miscompares++; $display("FAIL basic_ack: int %b pend %h want 0/0000", int_o, pending_o);
    end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick(); tick();
    vectors++;
    if (int_o !== 1'b0 || mcause_o !== 32'h8000_0013) begin
      miscompares++; $display("FAIL basic_mret: int %b mcause %h want 0/80000013", int_o, mcause_o);
    end
  endtask

  task automatic test_priority();
    mie_i = 32'hFFFF;
    irq_i = 16'h0024;
    tick();
    irq_i = '0;
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0012) begin
      miscompares++; $display("FAIL prio_first: int %b mcause %h want 1/80000012", int_o, mcause_o);
    end
    irq_i = 16'h0001; tick(); irq_i = '0;
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0012 || pending_o !== 16'h0025) begin
      miscompares++; $display("FAIL prio_commit: int %b mcause %h pend %h want 1/80000012/0025", int_o, mcause_o, pending_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    vectors++;
    if (pending_o !== 16'h0021) begin miscompares++; $display("FAIL prio_ack: pend %h want 0021", pending_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    vectors++;
    if (int_o !== 1'b0) begin miscompares++; $display("FAIL prio_gap: int %b want 0", int_o); end
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0010) begin
      miscompares++; $display("FAIL prio_second: int %b mcause %h want 1/80000010", int_o, mcause_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0015) begin
      miscompares++; $display("FAIL prio_third: int %b mcause %h want 1/80000015", int_o, mcause_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    vectors++;
    if (pending_o !== 16'h0) begin miscompares++; $display("FAIL prio_drain: pend %h want 0000", pending_o); end
  endtask

  task automatic test_mask();
    int seen = 0;
    mie_i = 32'h0;
    irq_i = 16'h0080;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int_o !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL mask_hold: int high %0d cycles want 0", seen); end
    vectors++;
    if (pending_o !== 16'h0080) begin miscompares++; $display("FAIL mask_pend: pend %h want 0080", pending_o); end
    mie_i = 32'h80;
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0017) begin
      miscompares++; $display("FAIL mask_enable: int %b mcause %h want 1/80000017", int_o, mcause_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    irq_i = '0;
    tick();
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0) begin
      miscompares++; $display("FAIL mask_level: int %b pend %h want 0/0000", int_o, pending_o);
    end
  endtask

  task automatic test_level_and_set_wins();
    int reqs = 0;
    mie_i = 32'hFFFF;
    irq_i = 16'h0002;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (int_ack_i) begin
        int_ack_i = 1'b0; mret_i = 1'b1;
      end else begin
        mret_i = 1'b0;
        if (int_o === 1'b1) begin reqs++; int_ack_i = 1'b1; end
      end
    end
    irq_i = '0; int_ack_i = 1'b0; mret_i = 1'b0;
    tick(); tick();
    vectors++;
    if (reqs != 1) begin miscompares++; $display("FAIL level_once: %0d requests want 1", reqs); end
    irq_i = 16'h0010; tick(); tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0014) begin
      miscompares++; $display("FAIL setwin_req: int %b mcause %h want 1/80000014", int_o, mcause_o);
    end
    irq_i = '0; tick();
    irq_i = 16'h0010; int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0010) begin
      miscompares++; $display("FAIL setwin_keep: int %b pend %h want 0/0010", int_o, pending_o);
    end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0014) begin
      miscompares++; $display("FAIL setwin_rereq: int %b mcause %h want 1/80000014", int_o, mcause_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    irq_i = '0; tick();
  endtask

  task automatic test_ignored();
    mie_i = 32'h0;
    irq_i = 16'h0200; tick(); irq_i = '0;
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0200) begin
      miscompares++; $display("FAIL ign_ack_idle: int %b pend %h want 0/0200", int_o, pending_o);
    end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0200) begin
      miscompares++; $display("FAIL ign_mret_idle: int %b pend %h want 0/0200", int_o, pending_o);
    end
    mie_i = 32'h200; tick();
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0019 || pending_o !== 16'h0200) begin
      miscompares++; $display("FAIL ign_mret_req: int %b mcause %h pend %h want 1/80000019/0200", int_o, mcause_o, pending_o);
    end
    int_ack_i = 1'b1; tick();
    mie_i = 32'hFFFF; irq_i = 16'h0100; tick(); int_ack_i = 1'b0;
    tick();
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0100 || mcause_o !== 32'h8000_0019) begin
      miscompares++; $display("FAIL ign_ack_svc: int %b pend %h mcause %h want 0/0100/80000019", int_o, pending_o, mcause_o);
    end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0018) begin
      miscompares++; $display("FAIL ign_resume: int %b mcause %h want 1/80000018", int_o, mcause_o);
    end
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    irq_i = '0; tick();
  endtask

  task automatic test_reset_mid();
    mie_i = 32'hFFFF;
    irq_i = 16'h000E; tick(); tick();
    vectors++;
    if (int_o !== 1'b1 || mcause_o !== 32'h8000_0011 || pending_o !== 16'h000E) begin
      miscompares++; $display("FAIL rstmid_pre: int %b mcause %h pend %h want 1/80000011/000E", int_o, mcause_o, pending_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if (int_o !== 1'b0 || mcause_o !== 32'h0 || pending_o !== 16'h0) begin
      miscompares++; $display("FAIL rstmid_async: int %b mcause %h pend %h want 0/0/0", int_o, mcause_o, pending_o);
    end
    irq_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(); tick();
    vectors++;
    if (int_o !== 1'b0 || pending_o !== 16'h0) begin
      miscompares++; $display("FAIL rstmid_after: int %b pend %h want 0/0000", int_o, pending_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_level_and_set_wins();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
